// File: rtl/rx_capture_ring.sv
// rx_capture_ring: trigger-capture ring buffer for the RX sample path.
// Samples are written continuously into an inferred dual-port RAM while armed.
// A trigger starts a programmable post-trigger count. When that count ends, the
// buffer freezes and can be read oldest-first through a registered read port.
// Optional feature macro: RX_CAPTURE_OUTREG_EN adds an output register after
// the RAM read, which raises read latency to 2 cycles with full throughput.
module rx_capture_ring #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              trigger,
    input  logic [ADDR_W-1:0] post_len,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_oor,
    output logic              armed,
    output logic              done,
    output logic [ADDR_W:0]   fill_cnt,
    output logic [ADDR_W-1:0] trig_idx
);

    localparam int              DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_POST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W:0]     r_fill_cnt;
    logic [ADDR_W-1:0]   r_post_cnt;
    logic [ADDR_W-1:0]   r_trig_ptr;
    logic [ADDR_W-1:0]   r_trig_idx;
    logic                r_armed;
    logic                r_done;

    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]     w_fill_nxt;
    logic [ADDR_W-1:0]   w_post_nxt;
    logic [ADDR_W-1:0]   w_trig_ptr_nxt;
    logic                w_we;
    logic [ADDR_W:0]     w_fill_inc;
    logic [ADDR_W-1:0]   w_oldest_nxt;
    logic [ADDR_W-1:0]   w_tidx_nxt;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DATA_W-1:0]   r_rd_word;
    logic                r_rd_valid1;
    logic                r_rd_oor1;
    logic [ADDR_W-1:0]   w_oldest;
    logic [ADDR_W-1:0]   w_rd_phys;
    logic                w_rd_oor;
    logic                w_rd_go;
    logic [DATA_W-1:0]   w_rd_data1;

    // Fill count saturates once every RAM slot holds a sample.
    assign w_fill_inc = (r_fill_cnt == FULL) ? FULL : (r_fill_cnt + (ADDR_W+1)'(1));

    // Next-state and capture bookkeeping; arm overrides everything else.
    always_comb begin
        w_state_nxt    = r_state;
        w_wr_ptr_nxt   = r_wr_ptr;
        w_fill_nxt     = r_fill_cnt;
        w_post_nxt     = r_post_cnt;
        w_trig_ptr_nxt = r_trig_ptr;
        w_we           = 1'b0;
        if (arm) begin
            w_state_nxt  = S_ARM;
            w_wr_ptr_nxt = '0;
            w_fill_nxt   = '0;
            w_post_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_IDLE;
                end
                S_ARM: begin
                    if (in_valid) begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                        w_fill_nxt   = w_fill_inc;
                        if (trigger) begin
                            w_trig_ptr_nxt = r_wr_ptr;
                            w_post_nxt     = post_len;
                            w_state_nxt    = (post_len == '0) ? S_DONE : S_POST;
                        end else begin
                            w_state_nxt = S_ARM;
                        end
                    end else begin
                        w_state_nxt = S_ARM;
                    end
                end
                S_POST: begin
                    if (in_valid) begin
                        w_we         = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + ADDR_W'(1);
                        w_fill_nxt   = w_fill_inc;
                        w_post_nxt   = r_post_cnt - ADDR_W'(1);
                        w_state_nxt  = (r_post_cnt == ADDR_W'(1)) ? S_DONE : S_POST;
                    end else begin
                        w_state_nxt = S_POST;
                    end
                end
                S_DONE: begin
                    w_state_nxt = S_DONE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Trigger index is computed from the post-update pointers so it is ready with done.
    assign w_oldest_nxt = w_wr_ptr_nxt - w_fill_nxt[ADDR_W-1:0];
    assign w_tidx_nxt   = w_trig_ptr_nxt - w_oldest_nxt;

    // Control state, counters and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_post_cnt <= '0;
            r_trig_ptr <= '0;
            r_trig_idx <= '0;
            r_armed    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_fill_cnt <= w_fill_nxt;
            r_post_cnt <= w_post_nxt;
            r_trig_ptr <= w_trig_ptr_nxt;
            r_trig_idx <= (w_state_nxt == S_DONE) ? w_tidx_nxt : '0;
            r_armed    <= (w_state_nxt == S_ARM) || (w_state_nxt == S_POST);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // Logical read index maps onto the ring starting at the oldest stored sample.
    assign w_oldest  = r_wr_ptr - r_fill_cnt[ADDR_W-1:0];
    assign w_rd_phys = w_oldest + rd_addr;
    assign w_rd_oor  = ({1'b0, rd_addr} >= r_fill_cnt);
    assign w_rd_go   = rd_req & r_done;

    // RAM write and synchronous read port; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_wr_ptr] <= in_data;
        end
        if (w_rd_go) begin
            r_rd_word <= r_mem[w_rd_phys];
        end
    end

    // First read stage qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid1 <= 1'b0;
            r_rd_oor1   <= 1'b0;
        end else begin
            r_rd_valid1 <= w_rd_go;
            r_rd_oor1   <= w_rd_go & w_rd_oor;
        end
    end

    // RAM word is masked so read data is zero when idle, out of range or after reset.
    assign w_rd_data1 = (r_rd_valid1 & ~r_rd_oor1) ? r_rd_word : '0;

`ifdef RX_CAPTURE_OUTREG_EN
    logic                r_rd_valid2;
    logic                r_rd_oor2;
    logic [DATA_W-1:0]   r_rd_data2;

    // Extra output register stage for timing closure after the RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_valid2 <= 1'b0;
            r_rd_oor2   <= 1'b0;
            r_rd_data2  <= '0;
        end else begin
            r_rd_valid2 <= r_rd_valid1;
            r_rd_oor2   <= r_rd_oor1;
            r_rd_data2  <= w_rd_data1;
        end
    end

    assign rd_valid = r_rd_valid2;
    assign rd_oor   = r_rd_oor2;
    assign rd_data  = r_rd_data2;
`else
    assign rd_valid = r_rd_valid1;
    assign rd_oor   = r_rd_oor1;
    assign rd_data  = w_rd_data1;
`endif

    assign armed    = r_armed;
    assign done     = r_done;
    assign fill_cnt = r_fill_cnt;
    assign trig_idx = r_trig_idx;

endmodule
